// File: rtl/inta_sequencer_pkg.sv
// pic_pkg: shared FSM state type, spurious level and lowest-set-bit helper for the PIC acknowledge path
package pic_pkg;
  localparam int NUM_IR = 8;
  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;
  typedef enum logic [1:0] {IDLE, PULSE1, WAIT2, PULSE2} state_t;
  // Returns {found, index}; index is the lowest set bit, which is the highest priority level.
  function automatic logic [3:0] lowest_set(input logic [NUM_IR-1:0] v);
    lowest_set = 4'b0;
    for (int i = NUM_IR - 1; i >= 0; i--)
      if (v[i]) lowest_set = {1'b1, 3'(i)};
  endfunction
endpackage

// File: rtl/inta_sequencer_resolver.sv
// pic_priority_resolver: fixed-priority (IR0 highest) resolution of pending vs in-service levels
// Ports: irr/imr/isr in; cand/cand_valid = best unmasked request, svc/svc_valid = level in service,
// qualify = cand may interrupt (nothing in service or cand strictly higher priority).
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] irr,
  input  logic [NUM_IR-1:0] imr,
  input  logic [NUM_IR-1:0] isr,
  output logic [2:0]        cand,
  output logic              cand_valid,
  output logic [2:0]        svc,
  output logic              svc_valid,
  output logic              qualify
);
  logic [NUM_IR-1:0] pend;
  assign pend = irr & ~imr;
  assign {cand_valid, cand} = lowest_set(pend);
  assign {svc_valid, svc} = lowest_set(isr);
  assign qualify = cand_valid && (!svc_valid || cand < svc);
endmodule

// File: rtl/inta_sequencer.sv
// inta_sequencer: raises the CPU interrupt, runs the two-pulse INTA sequence, owns ISR and the vector
// Ports: clk, reset_n (async, active low); irr/imr requests and mask; inta_n CPU acknowledge;
// aeoi auto-EOI enable; t_base vector high bits; eoi_valid/eoi_specific/eoi_level EOI command;
// int_req interrupt to CPU; highest_priority/current_pulse feed the IRR clear logic;
// isr in-service register; vector/vector_oe interrupt type and its drive enable.
module inta_sequencer
  import pic_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_IR-1:0] irr,
  input  logic [NUM_IR-1:0] imr,
  input  logic              inta_n,
  input  logic              aeoi,
  input  logic [4:0]        t_base,
  input  logic              eoi_valid,
  input  logic              eoi_specific,
  input  logic [2:0]        eoi_level,
  output logic              int_req,
  output logic [2:0]        highest_priority,
  output logic              current_pulse,
  output logic [NUM_IR-1:0] isr,
  output logic [7:0]        vector,
  output logic              vector_oe
);
  state_t state, state_n;
  logic inta_q, fall, rise, spurious, spurious_n, int_n, cp_n, voe_n;
  logic cand_valid, svc_valid, qualify;
  logic [2:0] cand, svc, hp_n;
  logic [NUM_IR-1:0] isr_set, aeoi_clr, eoi_clr, isr_n;
  pic_priority_resolver u_resolver (
    .irr        (irr),
    .imr        (imr),
    .isr        (isr),
    .cand       (cand),
    .cand_valid (cand_valid),
    .svc        (svc),
    .svc_valid  (svc_valid),
    .qualify    (qualify)
  );
  assign fall = inta_q & ~inta_n;
  assign rise = ~inta_q & inta_n;
  assign vector = {t_base, highest_priority};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state            <= IDLE;
      inta_q           <= 1'b1;
      int_req          <= 1'b0;
      highest_priority <= '0;
      current_pulse    <= 1'b0;
      isr              <= '0;
      vector_oe        <= 1'b0;
      spurious         <= 1'b0;
    end else begin
      state            <= state_n;
      inta_q           <= inta_n;
      int_req          <= int_n;
      highest_priority <= hp_n;
      current_pulse    <= cp_n;
      isr              <= isr_n;
      vector_oe        <= voe_n;
      spurious         <= spurious_n;
    end
  always_comb begin
    state_n    = state;
    hp_n       = highest_priority;
    cp_n       = current_pulse;
    voe_n      = vector_oe;
    spurious_n = spurious;
    isr_set    = '0;
    aeoi_clr   = '0;
    int_n      = (state == IDLE) && qualify;
    case (state)
      IDLE: if (fall) begin
        state_n    = PULSE1;
        cp_n       = 1'b1;
        int_n      = 1'b0;
        spurious_n = !qualify;
        hp_n       = qualify ? cand : SPURIOUS_LEVEL;
        isr_set    = qualify ? NUM_IR'(1) << cand : '0;
      end
      PULSE1: if (rise) state_n = WAIT2;
      WAIT2: if (fall) begin
        state_n = PULSE2;
        cp_n    = 1'b0;
        voe_n   = 1'b1;
      end
      PULSE2: if (rise) begin
        state_n  = IDLE;
        voe_n    = 1'b0;
        aeoi_clr = (aeoi && !spurious) ? NUM_IR'(1) << highest_priority : '0;
      end
      default: state_n = IDLE;
    endcase
    // EOI acts on the ISR as registered; an acknowledge set in the same cycle wins.
    eoi_clr = !eoi_valid ? '0 : eoi_specific ? NUM_IR'(1) << eoi_level : svc_valid ? NUM_IR'(1) << svc : '0;
    isr_n   = (isr & ~(eoi_clr | aeoi_clr)) | isr_set;
  end
endmodule

// File: tb/tb_inta_sequencer.sv
// tb_inta_sequencer: scoreboard bench for inta_sequencer; each step queues the expected output snapshot
module tb_inta_sequencer;
  logic clk = 0, reset_n = 0, inta_n = 1, aeoi = 0, eoi_valid = 0, eoi_specific = 0;
  logic [7:0] irr = 0, imr = 0;
  logic [4:0] t_base = 5'h08;
  logic [2:0] eoi_level = 0;
  logic int_req, current_pulse, vector_oe;
  logic [2:0] highest_priority;
  logic [7:0] isr, vector;
  int tests = 0, fails = 0;
  logic [21:0] exp_q[$], obs_q[$];
  string nm_q[$];
  inta_sequencer dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .irr              (irr),
    .imr              (imr),
    .inta_n           (inta_n),
    .aeoi             (aeoi),
    .t_base           (t_base),
    .eoi_valid        (eoi_valid),
    .eoi_specific     (eoi_specific),
    .eoi_level        (eoi_level),
    .int_req          (int_req),
    .highest_priority (highest_priority),
    .current_pulse    (current_pulse),
    .isr              (isr),
    .vector           (vector),
    .vector_oe        (vector_oe)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  // Queue the expected {int,cp,voe,hp,isr,vector}, optionally clock once, then capture the DUT.
  task automatic step(string nm, bit adv, logic i, logic c, logic v, logic [2:0] h, logic [7:0] s);
    exp_q.push_back({i, c, v, h, s, 5'h08, h});
    nm_q.push_back(nm);
    if (adv) begin
      @(posedge clk);
      @(negedge clk);
    end
    obs_q.push_back({int_req, current_pulse, vector_oe, highest_priority, isr, vector});
  endtask
  task automatic ack(string nm, logic [2:0] h, logic [7:0] s1, logic [7:0] s2, logic ev);
    inta_n = 0; eoi_valid = ev;
    step({nm, "_fall1"}, 1, 0, 1, 0, h, s1);
    eoi_valid = 0; irr = 0; inta_n = 1;
    step({nm, "_rise1"}, 1, 0, 1, 0, h, s1);
    inta_n = 0;
    step({nm, "_fall2"}, 1, 0, 0, 1, h, s1);
    inta_n = 1;
    step({nm, "_rise2"}, 1, 0, 0, 0, h, s2);
  endtask
  task automatic test_reset;
    logic [21:0] e, o;
    string n;
    reset_n = 0;
    repeat (2) @(negedge clk);
    step("reset_state", 0, 0, 0, 0, 3'd0, 8'h00);
    reset_n = 1;
    step("reset_idle", 1, 0, 0, 0, 3'd0, 8'h00);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL %s: got %h want %h", n, o, e); end
    end
  endtask
  task automatic test_basic;
    logic [21:0] e, o;
    string n;
    irr = 8'h20;
    step("basic_int", 1, 1, 0, 0, 3'd0, 8'h00);
    ack("basic", 3'd5, 8'h20, 8'h20, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL %s: got %h want %h", n, o, e); end
    end
  endtask
  task automatic test_nested;
    logic [21:0] e, o;
    string n;
    irr = 8'h80;
    step("nest_blocked", 1, 0, 0, 0, 3'd5, 8'h20);
    irr = 8'h04;
    step("nest_higher", 1, 1, 0, 0, 3'd5, 8'h20);
    ack("nest", 3'd2, 8'h24, 8'h24, 0);
    eoi_valid = 1; eoi_specific = 0;
    step("nest_ns_eoi", 1, 0, 0, 0, 3'd2, 8'h20);
    step("nest_ns_eoi2", 1, 0, 0, 0, 3'd2, 8'h00);
    eoi_valid = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL %s: got %h want %h", n, o, e); end
    end
  endtask
  task automatic test_aeoi;
    logic [21:0] e, o;
    string n;
    aeoi = 1; irr = 8'h02;
    step("aeoi_int", 1, 1, 0, 0, 3'd2, 8'h00);
    ack("aeoi", 3'd1, 8'h02, 8'h00, 0);
    step("aeoi_quiet", 1, 0, 0, 0, 3'd1, 8'h00);
    irr = 8'h10;
    step("aeoi_new_req", 1, 1, 0, 0, 3'd1, 8'h00);
    irr = 8'h00;
    step("aeoi_drop", 1, 0, 0, 0, 3'd1, 8'h00);
    aeoi = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL %s: got %h want %h", n, o, e); end
    end
  endtask
  task automatic test_spurious;
    logic [21:0] e, o;
    string n;
    irr = 8'h20;
    step("sp_int", 1, 1, 0, 0, 3'd1, 8'h00);
    ack("sp_real", 3'd5, 8'h20, 8'h20, 0);
    irr = 8'h80;
    step("sp_blocked", 1, 0, 0, 0, 3'd5, 8'h20);
    ack("sp_spur", 3'd7, 8'h20, 8'h20, 0);
    eoi_valid = 1; eoi_specific = 0;
    step("sp_eoi", 1, 0, 0, 0, 3'd7, 8'h00);
    eoi_valid = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL %s: got %h want %h", n, o, e); end
    end
  endtask
  task automatic test_specific_eoi;
    logic [21:0] e, o;
    string n;
    irr = 8'h08;
    step("se_int3", 1, 1, 0, 0, 3'd7, 8'h00);
    ack("se_ack3", 3'd3, 8'h08, 8'h08, 0);
    irr = 8'h02;
    step("se_int1", 1, 1, 0, 0, 3'd3, 8'h08);
    ack("se_ack1", 3'd1, 8'h0A, 8'h0A, 0);
    eoi_valid = 1; eoi_specific = 1; eoi_level = 3'd3;
    step("se_eoi3", 1, 0, 0, 0, 3'd1, 8'h02);
    eoi_specific = 0;
    step("se_ns", 1, 0, 0, 0, 3'd1, 8'h00);
    eoi_valid = 0; irr = 8'h08;
    step("se_int3b", 1, 1, 0, 0, 3'd1, 8'h00);
    eoi_specific = 1; eoi_level = 3'd3;
    ack("se_collide", 3'd3, 8'h08, 8'h08, 1);
    eoi_valid = 1;
    step("se_clr3", 1, 0, 0, 0, 3'd3, 8'h00);
    eoi_valid = 0; eoi_specific = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL %s: got %h want %h", n, o, e); end
    end
  endtask
  task automatic test_reset_mid;
    logic [21:0] e, o;
    string n;
    irr = 8'h20;
    step("rm_int", 1, 1, 0, 0, 3'd3, 8'h00);
    inta_n = 0;
    step("rm_pulse1", 1, 0, 1, 0, 3'd5, 8'h20);
    reset_n = 0; inta_n = 1;
    #1;
    step("rm_async", 0, 0, 0, 0, 3'd0, 8'h00);
    reset_n = 1;
    step("rm_reassert", 1, 1, 0, 0, 3'd0, 8'h00);
    irr = 8'h00;
    step("rm_clear", 1, 0, 0, 0, 3'd0, 8'h00);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL %s: got %h want %h", n, o, e); end
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_nested;
    test_aeoi;
    test_spurious;
    test_specific_eoi;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
